// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding and default sizing.
package fifo_wr_arbiter_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned BURST_LEN_DEF  = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StLock = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above rr_ptr, wrapping to 0.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  always_comb begin
    int unsigned      idx;
    logic [IW-1:0]    pos;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    pos    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      pos = IW'(idx);
      if (!valid && req[pos]) begin
        valid  = 1'b1;
        winner = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: N requesters share one FIFO write port, up to BURST_LEN beats per grant.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic                            fifo_full,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            fifo_w_en,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      owner
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(BURST_LEN + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          grant_en;
  logic [IW-1:0] grant_idx;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    grant_en   = 1'b0;
    grant_idx  = owner_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid && !fifo_full) begin
          grant_en   = 1'b1;
          grant_idx  = pick_idx;
          owner_d    = pick_idx;
          beat_cnt_d = CW'(1);
          if (BURST_LEN > 1) state_d = StLock;
          else               rr_ptr_d = wrap_inc(pick_idx);
        end
      end
      StLock: begin
        // Owner dropping its request costs one bubble cycle; others are never served here.
        if (!req[owner_q]) begin
          state_d  = StIdle;
          rr_ptr_d = wrap_inc(owner_q);
        end else if (!fifo_full) begin
          grant_en   = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_d == CW'(BURST_LEN)) begin
            state_d  = StIdle;
            rr_ptr_d = wrap_inc(owner_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Gating on rst keeps the grant path quiet while reset is held, not just after the next edge.
  always_comb begin
    gnt          = '0;
    fifo_data_in = '0;
    if (grant_en && rst) gnt = NUM_REQ'(1) << grant_idx;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) fifo_data_in = fifo_data_in | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_w_en = |gnt;
  assign busy      = (state_q == StLock);
  assign owner     = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter at NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data = 32'hA3A2_A1A0;
  logic        fifo_full = 1'b0;
  logic [3:0]  gnt;
  logic        fifo_w_en;
  logic [7:0]  fifo_data_in;
  logic        busy;
  logic [1:0]  owner;

  int checks = 0;
  int failures = 0;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .BURST_LEN (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .fifo_full    (fifo_full),
    .gnt          (gnt),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .busy         (busy),
    .owner        (owner)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_data(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return 8'hA0 + 8'(i);
    return 8'h00;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = 4'b0000; fifo_full = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got %b expected 0000", gnt); end
    checks++; if (fifo_w_en !== 1'b0) begin failures++; $display("FAIL rst_wen got %b expected 0", fifo_w_en); end
    checks++; if (fifo_data_in !== 8'h00) begin failures++; $display("FAIL rst_data got %h expected 00", fifo_data_in); end
    checks++; if (busy !== 1'b0 || owner !== 2'd0) begin failures++; $display("FAIL rst_busy_owner got %b/%0d expected 0/0", busy, owner); end
    @(negedge clk);
    rst = 1'b1; req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (gnt !== 4'b0000 || fifo_w_en !== 1'b0 || busy !== 1'b0 || owner !== 2'd0) begin
        failures++;
        $display("FAIL idle_noreq cycle %0d got gnt=%b wen=%b busy=%b owner=%0d expected 0000/0/0/0", c, gnt, fifo_w_en, busy, owner);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic       eb;
    logic [1:0] eo;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      eg = (c < 16) ? (4'b0001 << (c / 4)) : 4'b0001;
      eb = (c % 4) != 0;
      eo = (c == 0) ? 2'd0 : 2'((c - 1) / 4);
      #1;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL rr_gnt cycle %0d got %b expected %b", c, gnt, eg); end
      checks++; if (fifo_data_in !== exp_data(eg) || fifo_w_en !== 1'b1) begin failures++; $display("FAIL rr_data cycle %0d got %h/%b expected %h/1", c, fifo_data_in, fifo_w_en, exp_data(eg)); end
      checks++; if (busy !== eb || owner !== eo) begin failures++; $display("FAIL rr_state cycle %0d got busy=%b owner=%0d expected %b/%0d", c, busy, owner, eb, eo); end
      @(negedge clk);
    end
  endtask

  task automatic test_drop();
    logic [3:0] rq [8] = '{4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    logic [3:0] eg [8] = '{4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    logic       eb [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req = rq[c];
      #1;
      checks++; if (gnt !== eg[c]) begin failures++; $display("FAIL drop_gnt cycle %0d got %b expected %b", c, gnt, eg[c]); end
      checks++; if (fifo_data_in !== exp_data(eg[c]) || fifo_w_en !== (|eg[c])) begin failures++; $display("FAIL drop_data cycle %0d got %h/%b expected %h/%b", c, fifo_data_in, fifo_w_en, exp_data(eg[c]), |eg[c]); end
      checks++; if (busy !== eb[c]) begin failures++; $display("FAIL drop_busy cycle %0d got %b expected %b", c, busy, eb[c]); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic       fl [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] eg [9] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
    logic       eb [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] eo [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    do_reset();
    req = 4'b1010;
    for (int c = 0; c < 9; c++) begin
      fifo_full = fl[c];
      #1;
      checks++; if (gnt !== eg[c]) begin failures++; $display("FAIL stall_gnt cycle %0d got %b expected %b", c, gnt, eg[c]); end
      checks++; if (fifo_w_en !== (|eg[c])) begin failures++; $display("FAIL stall_wen cycle %0d got %b expected %b", c, fifo_w_en, |eg[c]); end
      checks++; if (busy !== eb[c] || owner !== eo[c]) begin failures++; $display("FAIL stall_state cycle %0d got busy=%b owner=%0d expected %b/%0d", c, busy, owner, eb[c], eo[c]); end
      @(negedge clk);
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_rr_ptr();
    logic [3:0] eg;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      req = (c < 4) ? 4'b0100 : 4'b1001;
      eg  = (c < 4) ? 4'b0100 : ((c < 8) ? 4'b1000 : 4'b0001);
      #1;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL ptr_gnt cycle %0d got %b expected %b", c, gnt, eg); end
      checks++; if (fifo_data_in !== exp_data(eg)) begin failures++; $display("FAIL ptr_data cycle %0d got %h expected %h", c, fifo_data_in, exp_data(eg)); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] eg;
    logic       eb;
    do_reset();
    req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL mid_beat1 got %b expected 0001", gnt); end
    @(negedge clk);
    #1;
    checks++; if (gnt !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL mid_beat2 got %b/%b expected 0001/1", gnt, busy); end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || fifo_w_en !== 1'b0 || fifo_data_in !== 8'h00 || busy !== 1'b0 || owner !== 2'd0) begin
      failures++;
      $display("FAIL mid_rst_out got gnt=%b wen=%b data=%h busy=%b owner=%0d expected all zero", gnt, fifo_w_en, fifo_data_in, busy, owner);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      eg = (c < 4) ? 4'b0001 : 4'b0010;
      eb = (c % 4) != 0;
      #1;
      checks++; if (gnt !== eg || busy !== eb) begin failures++; $display("FAIL mid_after cycle %0d got %b/%b expected %b/%b", c, gnt, busy, eg, eb); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_drop();
    test_stall();
    test_rr_ptr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
